// File: rtl/control_unit_mc.sv
// Multicycle control unit: fetch/decode/execute sequencer driving datapath selects and memory handshake.
// Optional retired-instruction counter is built only when CU_INSTRET_EN is defined.
module control_unit_mc (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_we,
  output logic        wb_sel,
  output logic [1:0]  ula_src_a,
  output logic [1:0]  ula_src_b,
  output logic [1:0]  ULAop,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  // state     | meaning
  // START     | idle after reset, no outputs
  // FETCH     | read instruction at PC, PC+4 on handshake
  // DECODE    | branch target precompute, dispatch on opcode
  // MEM_ADDR  | rs1 + imm effective address
  // MEM_READ  | load request, wait for mem_ready
  // MEM_WB    | write load data to register file
  // MEM_WRITE | store request, wait for mem_ready
  // EXEC_R    | register-register ALU op
  // EXEC_I    | register-immediate ALU op
  // ALU_WB    | write ALU result to register file
  // BRANCH    | compare, load PC with target when zero
  // ILLEGAL   | unsupported opcode, locked until reset
  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t cur, nxt;
  logic   fetch_q, branch_q;

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_START:     nxt = S_FETCH;
      S_FETCH:     if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_R:         nxt = S_EXEC_R;
          OP_I:         nxt = S_EXEC_I;
          OP_LD, OP_ST: nxt = S_MEM_ADDR;
          OP_BR:        nxt = S_BRANCH;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  nxt = (opcode == OP_ST) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WB:    nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
      S_EXEC_R:    nxt = S_ALU_WB;
      S_EXEC_I:    nxt = S_ALU_WB;
      S_ALU_WB:    nxt = S_FETCH;
      S_BRANCH:    nxt = S_FETCH;
      S_ILLEGAL:   nxt = S_ILLEGAL;
      default:     nxt = S_START;
    endcase
  end

  // Moore outputs are registered from the next state so they are glitch-free
  // and clear asynchronously with reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= S_START;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      iord      <= 1'b0;
      pc_src    <= 1'b0;
      reg_we    <= 1'b0;
      wb_sel    <= 1'b0;
      ula_src_a <= 2'b00;
      ula_src_b <= 2'b00;
      ULAop     <= 2'b00;
      illegal   <= 1'b0;
      fetch_q   <= 1'b0;
      branch_q  <= 1'b0;
    end else begin
      cur       <= nxt;
      mem_req   <= nxt inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
      mem_we    <= (nxt == S_MEM_WRITE);
      iord      <= nxt inside {S_MEM_READ, S_MEM_WRITE};
      pc_src    <= (nxt == S_BRANCH);
      reg_we    <= nxt inside {S_MEM_WB, S_ALU_WB};
      wb_sel    <= (nxt == S_MEM_WB);
      ula_src_a <= (nxt == S_DECODE) ? 2'b10 :
                   (nxt inside {S_MEM_ADDR, S_EXEC_R, S_EXEC_I, S_BRANCH}) ? 2'b01 : 2'b00;
      ula_src_b <= (nxt == S_FETCH) ? 2'b01 :
                   (nxt inside {S_DECODE, S_MEM_ADDR, S_EXEC_I}) ? 2'b10 : 2'b00;
      ULAop     <= (nxt == S_EXEC_R) ? 2'b10 : (nxt == S_BRANCH) ? 2'b01 : 2'b00;
      illegal   <= (nxt == S_ILLEGAL);
      fetch_q   <= (nxt == S_FETCH);
      branch_q  <= (nxt == S_BRANCH);
    end
  end

  // Strobes that depend on same-cycle handshake/flag inputs
  assign ir_we = fetch_q & mem_ready;
  assign pc_we = (fetch_q & mem_ready) | (branch_q & zero);
  assign state = cur;

`ifdef CU_INSTRET_EN
  logic [31:0] instret_q;
  logic        retire;

  assign retire = (cur inside {S_MEM_WB, S_ALU_WB, S_BRANCH}) ||
                  ((cur == S_MEM_WRITE) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule
